xtal_clock_qualifier: RTL and testbench
=======================================

Name: xtal_clock_qualifier

Overview:
Consumes the differential ClockP/ClockN pair from the crystal oscillator stage and qualifies it before downstream logic is released. Samples both legs in the system Clock domain, counts ClockP rising edges per fixed measurement window and checks that the legs stay complementary. Asserts ClockGood only after a run of consecutive in-range windows, and reports fault type otherwise. Sits directly downstream of the oscillator, ahead of clock-switch and reset-release logic.

Parameters:
WINDOW, 256, system Clock cycles per measurement window (power of two, ≥16)
MIN_EDGES, 60, minimum acceptable ClockP rising edges per window
MAX_EDGES, 68, maximum acceptable ClockP rising edges per window
LOCK_WINDOWS, 4, consecutive good windows required to assert ClockGood
SKEW_LIMIT, 3, max consecutive sampled cycles with ClockP==ClockN tolerated
COUNT_W, 16, width of edge counter and EdgeCount output

Ports:
Clock  input  1  system clock, ≥4x crystal frequency
ResetN  input  1  asynchronous active-low reset
ClockP  input  1  oscillator true leg, asynchronous to Clock
ClockN  input  1  oscillator complement leg, asynchronous to Clock
FaultClear  input  1  single-cycle fault acknowledge (used only with sticky feature)
ClockGood  output  1  crystal qualified
Fault  output  1  fault state active
FaultCode  output  2  0 none, 1 slow/dead, 2 fast, 3 skew
EdgeCount  output  COUNT_W  edge count of last completed window

Behaviour:
- Reset is asynchronous, active-low; one clock (Clock). While ResetN=0: ClockGood=0, Fault=0, FaultCode=0, EdgeCount=0, all counters 0, state STARTUP, synchronizers cleared.
- ClockP and ClockN each pass through a 2-flop synchronizer; rising-edge detect on synced ClockP (compare with its previous value). Pin-to-edge-event latency 3 Clock cycles.
- Window counter runs 0..WINDOW-1 continuously, wraps; end-of-window (EOW) is the cycle the counter equals WINDOW-1. Edge counter increments per edge, saturates at all-ones, clears on EOW; an edge landing on EOW counts toward the closing window.
- On EOW: EdgeCount <= final count (including an EOW-cycle edge). Window good iff MIN_EDGES ≤ count ≤ MAX_EDGES; else slow (count<MIN, includes 0) or fast (count>MAX).
- Skew: counter of consecutive cycles synced ClockP==ClockN, cleared when they differ; reaching SKEW_LIMIT+1 is a skew event (immediate, not at EOW), counter then holds until legs differ.
- States:
  STARTUP: first window discarded; at EOW -> MEASURE, GoodRun=0.
  MEASURE: good EOW increments GoodRun; when GoodRun reaches LOCK_WINDOWS -> LOCKED, ClockGood=1 the following cycle. Bad EOW: GoodRun=0, FaultCode updated, stay MEASURE. Skew event: GoodRun=0, FaultCode=3. Fault stays 0 in MEASURE.
  LOCKED: ClockGood=1, FaultCode=0. Bad EOW or skew event -> FAULT; ClockGood drops, Fault=1 and FaultCode set on the next cycle.
  FAULT: ClockGood=0, Fault=1. Next EOW -> MEASURE, GoodRun=0, Fault=0, FaultCode retained until a good EOW.
- Simultaneous skew event and EOW: skew wins (FaultCode=3, window ignored).
- FaultClear ignored when feature absent.

Optional Feature:
XTAL_STICKY_FAULT_EN: defined -> FAULT is sticky; exit only on FaultClear=1, then -> MEASURE, GoodRun=0 on the next cycle; FaultCode held until clear. FaultClear in any other state ignored. Undefined -> FAULT auto-exits at next EOW as above.

Test Plan:
- Nominal: Clock 4x crystal, 64 edges/window -> EdgeCount=64 each EOW, ClockGood=1 one cycle after 5th EOW (startup + 4), Fault=0.
- Dead crystal after lock: hold ClockP=0, ClockN=1 -> next EOW EdgeCount=0, then ClockGood=0, Fault=1, FaultCode=1.
- Fast crystal in MEASURE: 80 edges/window -> FaultCode=2, GoodRun reset, ClockGood never asserts; restore 64 -> ClockGood after 4 good windows.
- Skew after lock: force ClockP=ClockN=1 for 4 synced cycles -> skew event, next cycle Fault=1, FaultCode=3; 3-cycle overlap produces no fault.
- Reset mid-lock: ResetN=0 for 1 cycle while LOCKED -> outputs 0 immediately; relock requires startup + 4 windows.
- Sticky (macro on): induce fault, no FaultClear for 3 windows -> Fault stays 1; pulse FaultClear -> Fault=0 next cycle, lock after 4 good windows.

Source files
------------

// File: rtl/xtal_clock_qualifier_if.sv
// Oscillator legs, fault acknowledge and qualification status of xtal_clock_qualifier.
// The master side drives the crystal legs; the slave side is the qualifier.
interface xtal_clock_qualifier_if #(
  parameter int unsigned COUNT_W = 16
);
  logic               clock_p;
  logic               clock_n;
  logic               fault_clear;
  logic               clock_good;
  logic               fault;
  logic [1:0]         fault_code;
  logic [COUNT_W-1:0] edge_count;

  modport master (
    output clock_p, clock_n, fault_clear,
    input  clock_good, fault, fault_code, edge_count
  );

  modport slave (
    input  clock_p, clock_n, fault_clear,
    output clock_good, fault, fault_code, edge_count
  );
endinterface

// File: rtl/xtal_clock_qualifier.sv
// Qualifies a differential crystal clock by per-window edge counting and leg-complement checking.
// Optional XTAL_STICKY_FAULT_EN: FAULT is left only through fault_clear instead of at the next window end.
module xtal_clock_qualifier #(
  parameter int unsigned WINDOW       = 256,
  parameter int unsigned MIN_EDGES    = 60,
  parameter int unsigned MAX_EDGES    = 68,
  parameter int unsigned LOCK_WINDOWS = 4,
  parameter int unsigned SKEW_LIMIT   = 3,
  parameter int unsigned COUNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  xtal_clock_qualifier_if.slave  bus_if
);
  localparam int unsigned WIN_W  = $clog2(WINDOW);
  localparam int unsigned RUN_W  = $clog2(LOCK_WINDOWS + 1);
  localparam int unsigned SKEW_W = $clog2(SKEW_LIMIT + 2);

  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_SLOW = 2'd1;
  localparam logic [1:0] CODE_FAST = 2'd2;
  localparam logic [1:0] CODE_SKEW = 2'd3;

  typedef enum logic [1:0] {ST_STARTUP, ST_MEASURE, ST_LOCKED, ST_FAULT} state_e;

  state_e              state_q, state_d;
  logic [1:0]          p_sync_q, n_sync_q;
  logic                p_prev_q;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [COUNT_W-1:0]  edge_cnt_q, edge_cnt_d, edge_total;
  logic [SKEW_W-1:0]   skew_cnt_q, skew_cnt_d;
  logic [RUN_W-1:0]    good_run_q, good_run_d;
  logic [1:0]          fault_code_q, fault_code_d;
  logic [COUNT_W-1:0]  edge_count_q, edge_count_d;
  logic                clock_good_q, fault_q;
  logic                edge_evt, legs_eq, eow, skew_evt, win_slow, win_fast, win_ok;
  logic [1:0]          win_code;

  // Window bookkeeping; an edge on the closing cycle still belongs to that window.
  assign edge_evt   = p_sync_q[1] & ~p_prev_q;
  assign legs_eq    = (p_sync_q[1] == n_sync_q[1]);
  assign eow        = (win_cnt_q == WIN_W'(WINDOW - 1));
  assign win_cnt_d  = win_cnt_q + WIN_W'(1);
  assign edge_total = (edge_evt && (edge_cnt_q != '1)) ? edge_cnt_q + COUNT_W'(1) : edge_cnt_q;
  assign edge_cnt_d = eow ? '0 : edge_total;
  assign win_slow   = (edge_total < COUNT_W'(MIN_EDGES));
  assign win_fast   = (edge_total > COUNT_W'(MAX_EDGES));
  assign win_ok     = ~win_slow & ~win_fast;
  assign win_code   = win_slow ? CODE_SLOW : CODE_FAST;
  assign edge_count_d = eow ? edge_total : edge_count_q;

  // Skew fires once on reaching SKEW_LIMIT+1 equal cycles, then holds until the legs differ.
  assign skew_evt   = legs_eq && (skew_cnt_q == SKEW_W'(SKEW_LIMIT));
  assign skew_cnt_d = !legs_eq ? '0 :
                      (skew_cnt_q == SKEW_W'(SKEW_LIMIT + 1)) ? skew_cnt_q :
                      skew_cnt_q + SKEW_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STARTUP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    good_run_d   = good_run_q;
    fault_code_d = fault_code_q;
    unique case (state_q)
      ST_STARTUP: begin
        if (eow) begin
          state_d    = ST_MEASURE;
          good_run_d = '0;
        end
      end
      ST_MEASURE: begin
        if (skew_evt) begin
          good_run_d   = '0;
          fault_code_d = CODE_SKEW;
        end else if (eow) begin
          if (win_ok) begin
            fault_code_d = CODE_NONE;
            if (good_run_q == RUN_W'(LOCK_WINDOWS - 1)) begin
              state_d    = ST_LOCKED;
              good_run_d = RUN_W'(LOCK_WINDOWS);
            end else begin
              good_run_d = good_run_q + RUN_W'(1);
            end
          end else begin
            good_run_d   = '0;
            fault_code_d = win_code;
          end
        end
      end
      ST_LOCKED: begin
        fault_code_d = CODE_NONE;
        if (skew_evt) begin
          state_d      = ST_FAULT;
          fault_code_d = CODE_SKEW;
        end else if (eow && !win_ok) begin
          state_d      = ST_FAULT;
          fault_code_d = win_code;
        end
      end
      ST_FAULT: begin
`ifdef XTAL_STICKY_FAULT_EN
        if (bus_if.fault_clear) begin
          state_d      = ST_MEASURE;
          good_run_d   = '0;
          fault_code_d = CODE_NONE;
        end
`else
        if (eow) begin
          state_d    = ST_MEASURE;
          good_run_d = '0;
        end
`endif
      end
      default: state_d = ST_STARTUP;
    endcase
  end

`ifndef XTAL_STICKY_FAULT_EN
  logic unused_fault_clear;
  assign unused_fault_clear = bus_if.fault_clear;
`endif

  // Synchronizers, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_sync_q     <= '0;
      n_sync_q     <= '0;
      p_prev_q     <= 1'b0;
      win_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      skew_cnt_q   <= '0;
      good_run_q   <= '0;
      fault_code_q <= CODE_NONE;
      edge_count_q <= '0;
      clock_good_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      p_sync_q     <= {p_sync_q[0], bus_if.clock_p};
      n_sync_q     <= {n_sync_q[0], bus_if.clock_n};
      p_prev_q     <= p_sync_q[1];
      win_cnt_q    <= win_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      skew_cnt_q   <= skew_cnt_d;
      good_run_q   <= good_run_d;
      fault_code_q <= fault_code_d;
      edge_count_q <= edge_count_d;
      clock_good_q <= (state_d == ST_LOCKED);
      fault_q      <= (state_d == ST_FAULT);
    end
  end

  assign bus_if.clock_good = clock_good_q;
  assign bus_if.fault      = fault_q;
  assign bus_if.fault_code = fault_code_q;
  assign bus_if.edge_count = edge_count_q;
endmodule

// File: tb/tb_xtal_clock_qualifier.sv
// Directed bench for xtal_clock_qualifier; crystal patterns are phase-locked to the bench cycle count.
// Sticky-fault steps run only when XTAL_STICKY_FAULT_EN is defined.
module tb_xtal_clock_qualifier;
  localparam int COUNT_W = 16;
  localparam int M_DEAD  = 0;
  localparam int M_NOM   = 1;
  localparam int M_FAST  = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc;
  int   mode;
  logic force_eq;
  logic clear;
  logic p_lvl;
  int   n_vec;
  int   n_err;

  xtal_clock_qualifier_if #(.COUNT_W(COUNT_W)) bus_if ();

  xtal_clock_qualifier #(
    .WINDOW(256), .MIN_EDGES(60), .MAX_EDGES(68),
    .LOCK_WINDOWS(4), .SKEW_LIMIT(3), .COUNT_W(COUNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  // Bench cycle count tracks the window position after reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Nominal: rise every 4 cycles (64/window). Fast: rises at phases 0,3,6,9,12 of 16 (80/window).
  function automatic logic level(input int c, input int m);
    if (m == M_NOM)  return ((c % 4) < 2);
    if (m == M_FAST) return (((c % 16) % 3) == 0) && ((c % 16) <= 12);
    return 1'b0;
  endfunction

  assign p_lvl              = force_eq ? 1'b1 : level(cyc, mode);
  assign bus_if.clock_p     = p_lvl;
  assign bus_if.clock_n     = force_eq ? 1'b1 : ~p_lvl;
  assign bus_if.fault_clear = clear;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic goto(input int c);
    int guard = 0;
    while (cyc != c) begin
      @(negedge clk);
      guard++;
      if (guard > 20000) begin
        n_vec++;
        n_err++;
        $display("FAIL goto: observed cyc %0d expected %0d", cyc, c);
        return;
      end
    end
  endtask

  task automatic status(input string tag, input logic good, input logic flt, input logic [1:0] code);
    chk({tag, "_good"},  32'(bus_if.clock_good), 32'(good));
    chk({tag, "_fault"}, 32'(bus_if.fault),      32'(flt));
    chk({tag, "_code"},  32'(bus_if.fault_code), 32'(code));
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    mode = M_NOM; force_eq = 1'b0; clear = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    status("reset", 1'b0, 1'b0, 2'd0);
    chk("reset_edges", 32'(bus_if.edge_count), 32'd0);
    rst_n = 1'b1;

    // Startup window discarded, then four good windows to lock.
    goto(256);  status("startup_eow", 1'b0, 1'b0, 2'd0);
    chk("startup_edges", 32'(bus_if.edge_count), 32'd64);
    goto(1279); chk("prelock_good", 32'(bus_if.clock_good), 32'd0);
    goto(1280); status("locked", 1'b1, 1'b0, 2'd0);
    chk("locked_edges", 32'(bus_if.edge_count), 32'd64);

    // Three overlapping cycles are tolerated.
    goto(1380); force_eq = 1'b1;
    repeat (3) @(negedge clk);
    force_eq = 1'b0;
    goto(1395); status("skew3", 1'b1, 1'b0, 2'd0);
    goto(1536); chk("skew3_edges", 32'(bus_if.edge_count), 32'd64);

    // Four overlapping cycles fault from LOCKED.
    goto(1636); force_eq = 1'b1;
    repeat (4) @(negedge clk);
    force_eq = 1'b0;
    goto(1641); status("skew4_pre", 1'b1, 1'b0, 2'd0);
    goto(1642); status("skew4_fault", 1'b0, 1'b1, 2'd3);
    goto(1792); status("skew_exit", 1'b0, 1'b0, 2'd3);
    chk("skew_win_edges", 32'(bus_if.edge_count), 32'd63);
    goto(2048); status("skew_recover", 1'b0, 1'b0, 2'd0);
    goto(2815); chk("relock_pre", 32'(bus_if.clock_good), 32'd0);
    goto(2816); chk("relock", 32'(bus_if.clock_good), 32'd1);

    // Dead crystal after lock.
    mode = M_DEAD;
    goto(3071); status("dead_pre", 1'b1, 1'b0, 2'd0);
    goto(3072); status("dead_fault", 1'b0, 1'b1, 2'd1);
    chk("dead_edges", 32'(bus_if.edge_count), 32'd0);
`ifndef XTAL_STICKY_FAULT_EN
    goto(3100); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    @(negedge clk); status("clear_ignored", 1'b0, 1'b1, 2'd1);
`endif
    goto(3328); status("dead_exit", 1'b0, 1'b0, 2'd1);

    // Fast crystal while measuring, then recover.
    mode = M_FAST;
    goto(3584); status("fast", 1'b0, 1'b0, 2'd2);
    chk("fast_edges", 32'(bus_if.edge_count), 32'd80);
    goto(3840); chk("fast2_good", 32'(bus_if.clock_good), 32'd0);
    mode = M_NOM;
    goto(4096); status("fast_recover", 1'b0, 1'b0, 2'd0);
    chk("recover_edges", 32'(bus_if.edge_count), 32'd64);
    goto(4863); chk("fast_lock_pre", 32'(bus_if.clock_good), 32'd0);
    goto(4864); chk("fast_lock", 32'(bus_if.clock_good), 32'd1);

    // Short reset while locked.
    goto(4900); rst_n = 1'b0;
    #1;
    status("midreset", 1'b0, 1'b0, 2'd0);
    chk("midreset_edges", 32'(bus_if.edge_count), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    goto(1279); chk("rst_relock_pre", 32'(bus_if.clock_good), 32'd0);
    goto(1280); status("rst_relock", 1'b1, 1'b0, 2'd0);

`ifdef XTAL_STICKY_FAULT_EN
    mode = M_DEAD;
    goto(1536); status("sticky_fault", 1'b0, 1'b1, 2'd1);
    goto(2304); status("sticky_hold", 1'b0, 1'b1, 2'd1);
    mode = M_NOM; clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    status("sticky_clear", 1'b0, 1'b0, 2'd0);
    goto(3327); chk("sticky_lock_pre", 32'(bus_if.clock_good), 32'd0);
    goto(3328); chk("sticky_lock", 32'(bus_if.clock_good), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
